// File: rtl/eq_buff_reader_demap_if.sv
// Bus between the equalizer output buffer, the QPSK demap reader and the byte sink.
// The master modport is the reader; the slave modport is the buffer and sink side.
interface eq_buff_reader_demap_if;
   logic        out_buff_full;
   logic [15:0] din;
   logic [7:0]  read_ptr;
   logic        tx_done;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;

   modport master (
      input  out_buff_full, din, m_ready,
      output read_ptr, tx_done, m_data, m_valid
   );

   modport slave (
      output out_buff_full, din, m_ready,
      input  read_ptr, tx_done, m_data, m_valid
   );
endinterface

// File: rtl/eq_buff_reader_demap.sv
// Reads one equalized burst, hard-demaps QPSK to bytes and streams them out through a small FIFO.
// Optional descrambling: define DEMAP_DESCRAMBLE_EN to XOR each byte with PRBS x^7+x^4+1.
module eq_buff_reader_demap #(
   parameter int N_SC       = 28,
   parameter int N_SYM      = 8,
   parameter int RD_LAT     = 3,
   parameter int FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   eq_buff_reader_demap_if.master bus
);

   localparam int TOTAL = N_SC * N_SYM;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCW   = AW + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     rd_cnt;
   logic [7:0]        ptr_q;
   logic [RD_LAT-1:0] vld_sr;
   logic [1:0]        cap_cnt;
   logic [7:0]        pack;
   logic              pend_valid;
   logic [7:0]        pend_byte;
   logic [FCW-1:0]    fifo_count;
   logic [FCW-1:0]    in_flight;
   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_idx, rd_idx;
   logic              ignore_full;

   logic              start, issue, grp_start, group_ok, last_issue;
   logic              capture, push, pop, drained;
   logic [7:0]        cap_byte, push_byte;
   logic              unused_din_bits;

   assign unused_din_bits = ^{bus.din[14:8], bus.din[6:0]};

   // A new group of four addresses may start only when its byte is guaranteed a FIFO slot.
   always_comb begin
      start      = (state == IDLE) && bus.out_buff_full && !ignore_full;
      group_ok   = ({1'b0, fifo_count} + {1'b0, in_flight}) < (FCW + 1)'(FIFO_DEPTH);
      issue      = (state == READ) && ((rd_cnt[1:0] != 2'b00) || group_ok);
      grp_start  = issue && (rd_cnt[1:0] == 2'b00);
      last_issue = issue && (rd_cnt == CW'(TOTAL - 1));
      capture    = vld_sr[RD_LAT-1];
      push       = pend_valid;
      pop        = bus.m_valid && bus.m_ready;
      drained    = (vld_sr == '0) && !pend_valid && (fifo_count == '0) && (in_flight == '0);
      cap_byte   = pack;
      cap_byte[{cap_cnt, 1'b0} +: 2] = {bus.din[15], bus.din[7]};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = READ;
         READ:  if (last_issue) state_nxt = DRAIN;
         DRAIN: if (drained) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

`ifdef DEMAP_DESCRAMBLE_EN
   logic [6:0] prbs, prbs_nxt;
   logic [7:0] scr_bits;

   // Eight PRBS steps per byte; the first generated bit lands in the byte LSB.
   always_comb begin
      prbs_nxt = prbs;
      scr_bits = '0;
      for (int i = 0; i < 8; i++) begin
         scr_bits[i] = prbs_nxt[6] ^ prbs_nxt[3];
         prbs_nxt    = {prbs_nxt[5:0], scr_bits[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     prbs <= 7'h7F;
      else if (start) prbs <= 7'h7F;
      else if (push)  prbs <= prbs_nxt;
   end

   assign push_byte = pend_byte ^ scr_bits;
`else
   assign push_byte = pend_byte;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt      <= '0;
         ptr_q       <= '0;
         vld_sr      <= '0;
         cap_cnt     <= '0;
         pack        <= '0;
         pend_valid  <= 1'b0;
         pend_byte   <= '0;
         in_flight   <= '0;
         ignore_full <= 1'b0;
      end else begin
         ignore_full <= (state == DONE);
         vld_sr      <= (vld_sr << 1) | RD_LAT'(issue);
         pend_valid  <= capture && (cap_cnt == 2'd3);
         if (start) begin
            rd_cnt  <= '0;
            cap_cnt <= '0;
            pack    <= '0;
         end
         if (issue) begin
            ptr_q  <= 8'(rd_cnt);
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (capture) begin
            cap_cnt <= cap_cnt + 1'b1;
            if (cap_cnt == 2'd3) begin
               pack      <= '0;
               pend_byte <= cap_byte;
            end else begin
               pack <= cap_byte;
            end
         end
         // Bytes in flight are counted from group start until their FIFO push.
         case ({grp_start, push})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_idx     <= '0;
         rd_idx     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_idx] <= push_byte;
            wr_idx           <= wr_idx + 1'b1;
         end
         if (pop) rd_idx <= rd_idx + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (!push && pop) fifo_count <= fifo_count - 1'b1;
      end
   end

   assign bus.read_ptr = ptr_q;
   assign bus.tx_done  = (state == DONE);
   assign bus.m_valid  = (fifo_count != '0);
   assign bus.m_data   = fifo_mem[rd_idx];

endmodule

// File: tb/tb_eq_buff_reader_demap.sv
// Directed bench for eq_buff_reader_demap: models the equalizer buffer read pipeline and a byte sink.
// Expected bytes come from hand-computed pattern values, optionally XORed with a bench PRBS model.
module tb_eq_buff_reader_demap;
   localparam int RD_LAT = 3;
   localparam int FD     = 4;
   localparam int NB     = 56;
   localparam int NS     = 224;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eq_buff_reader_demap_if bus();

   eq_buff_reader_demap #(.N_SC(28), .N_SYM(8), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Buffer model: the sample for an address set on edge t is presented at edge t+RD_LAT.
   logic [15:0] mem [256];
   logic [15:0] p1, p2;
   always @(posedge clk) begin
      p1 <= mem[bus.read_ptr];
      p2 <= p1;
   end
   assign bus.din = p2;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_q [$];
   int         tx_cnt = 0;
   int         tx_wide = 0;
   logic       tx_prev = 1'b0;
   logic [7:0] exp_b [NB];
   logic [7:0] scr [NB];
   int         start_tx;

   always @(negedge clk) begin
      if (rst_n && bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
      if (bus.tx_done) begin
         tx_cnt++;
         if (tx_prev) tx_wide++;
      end
      tx_prev = bus.tx_done;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic initScrambler();
      logic [6:0] s;
      logic       b;
      s = 7'h7F;
      for (int j = 0; j < NB; j++) begin
         scr[j] = 8'h00;
`ifdef DEMAP_DESCRAMBLE_EN
         for (int i = 0; i < 8; i++) begin
            b         = s[6] ^ s[3];
            s         = {s[5:0], b};
            scr[j][i] = b;
         end
`endif
      end
   endtask

   // kind 0: all 8080 -> FF, 1: alternating 7F80/807F -> 99, 2: ramp bytes, 3: all zero -> 00
   task automatic loadPattern(input int kind);
      logic [7:0] raw;
      logic [1:0] b;
      for (int j = 0; j < NB; j++) begin
         case (kind)
            0:       raw = 8'hFF;
            1:       raw = 8'h99;
            2:       raw = 8'(j * 37 + 5);
            default: raw = 8'h00;
         endcase
         exp_b[j] = raw ^ scr[j];
         for (int k = 0; k < 4; k++) begin
            case (kind)
               0: mem[4*j+k] = 16'h8080;
               1: mem[4*j+k] = (k % 2 == 0) ? 16'h7F80 : 16'h807F;
               2: begin
                  b = raw[2*k +: 2];
                  mem[4*j+k] = {b[1], 7'h15, b[0], 7'h2A};
               end
               default: mem[4*j+k] = 16'h0000;
            endcase
         end
      end
   endtask

   task automatic applyStimulus(input int kind);
      loadPattern(kind);
      rx_q.delete();
      start_tx = tx_cnt;
      @(posedge clk) #1;
      bus.out_buff_full = 1'b1;
   endtask

   task automatic waitLatency(output int lat);
      lat = 0;
      @(posedge clk);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.m_valid) break;
         lat++;
      end
   endtask

   // Holds out_buff_full one extra cycle past tx_done, then checks no second burst starts.
   task automatic finishBurst(input string tag);
      logic ok;
      int   n;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk) #1;
         if (tx_cnt > start_tx) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_tx_seen"}, 32'(ok), 32'd1);
      @(posedge clk) #1;
      bus.out_buff_full = 1'b0;
      n = rx_q.size();
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_no_restart"}, 32'(rx_q.size()), 32'(n));
      checkOutput({tag, "_idle_valid"}, 32'(bus.m_valid), 32'd0);
      checkOutput({tag, "_tx_pulses"}, 32'(tx_cnt - start_tx), 32'd1);
      checkOutput({tag, "_tx_width"}, 32'(tx_wide), 32'd0);
   endtask

   task automatic checkBytes(input string tag);
      int n;
      n = rx_q.size();
      checkOutput({tag, "_byte_count"}, 32'(n), 32'(NB));
      for (int j = 0; j < NB && j < n; j++)
         checkOutput($sformatf("%s_byte%0d", tag, j), 32'(rx_q[j]), 32'(exp_b[j]));
   endtask

   initial begin
      int   lat;
      int   n;
      logic ok;

      bus.out_buff_full = 1'b0;
      bus.m_ready       = 1'b1;
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
      initScrambler();

      $display("[TB] reset values");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_read_ptr", 32'(bus.read_ptr), 32'd0);
      checkOutput("rst_tx_done", 32'(bus.tx_done), 32'd0);
      checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
      checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
      @(posedge clk) #1;
      rst_n = 1'b1;

      $display("[TB] all 8080 burst with latency");
      applyStimulus(0);
      waitLatency(lat);
      checkOutput("first_valid_latency", 32'(lat), 32'(RD_LAT + 5));
      finishBurst("ff");
      checkBytes("ff");

      $display("[TB] alternating burst");
      applyStimulus(1);
      finishBurst("alt");
      checkBytes("alt");

      $display("[TB] all zero burst");
      applyStimulus(3);
      finishBurst("zero");
      checkBytes("zero");

      $display("[TB] sink stall");
      applyStimulus(2);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk) #1;
         if (rx_q.size() >= 10) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("stall_reach", 32'(ok), 32'd1);
      bus.m_ready = 1'b0;
      n = rx_q.size();
      for (int h = 0; h < 2; h++) begin
         repeat (25) @(posedge clk);
         @(negedge clk);
         checkOutput("stall_m_valid", 32'(bus.m_valid), 32'd1);
         checkOutput("stall_m_data", 32'(bus.m_data), 32'(exp_b[n]));
         checkOutput("stall_read_ptr", 32'(bus.read_ptr), 32'(4 * (n + FD) - 1));
         checkOutput("stall_no_transfer", 32'(rx_q.size()), 32'(n));
      end
      @(posedge clk) #1;
      bus.m_ready = 1'b1;
      finishBurst("stall");
      checkBytes("stall");

      $display("[TB] reset mid-burst");
      applyStimulus(2);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.read_ptr == 8'd100) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("midrst_reach", 32'(ok), 32'd1);
      @(posedge clk) #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_read_ptr", 32'(bus.read_ptr), 32'd0);
      checkOutput("midrst_m_valid", 32'(bus.m_valid), 32'd0);
      checkOutput("midrst_m_data", 32'(bus.m_data), 32'd0);
      checkOutput("midrst_tx_done", 32'(bus.tx_done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      bus.out_buff_full = 1'b0;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      checkOutput("midrst_no_tx", 32'(tx_cnt - start_tx), 32'd0);
      applyStimulus(2);
      finishBurst("after_rst");
      checkBytes("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eq_buff_reader_demap.md
EQ_BUFF_READER_DEMAP -- requirements
Module: eq_buff_reader_demap

Interface
REQ-001 SHALL provide parameter N_SC, default 28, active subcarriers per OFDM symbol.
REQ-002 SHALL provide parameter N_SYM, default 8, data symbols per burst.
REQ-003 SHALL provide parameter RD_LAT, default 3, cycles from read_ptr change to matching dout.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 4, output byte FIFO entries (power of 2).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port out_buff_full, input, 1, equalizer output buffer holds a complete burst.
REQ-008 SHALL have port din, input, 16, equalized sample {im[15:8], re[7:0]}, two's complement.
REQ-009 SHALL have port read_ptr, output, 8, equalizer output buffer read address.
REQ-010 SHALL have port tx_done, output, 1, one-cycle burst-consumed pulse that clears the equalizer.
REQ-011 SHALL have port m_data, output, 8, demapped byte.
REQ-012 SHALL have port m_valid, output, 1, m_data valid.
REQ-013 SHALL have port m_ready, input, 1, sink accepts byte.

Function
REQ-014 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE SHALL move to READ on the first cycle out_buff_full=1, clearing rd_cnt, cap_cnt and pack state.
REQ-016 READ SHALL issue read_ptr = rd_cnt, with rd_cnt 0..N_SC*N_SYM-1 (0..223), at most one address per cycle.
REQ-017 A new group of 4 addresses SHALL start only if fifo_count + bytes_in_flight < FIFO_DEPTH; otherwise read_ptr holds its value.
REQ-018 Data SHALL be captured from din exactly RD_LAT cycles after each issued address, tracked by an RD_LAT-deep valid shift register.
REQ-019 QPSK hard demap: per sample b1 = din[15] (im sign), b0 = din[7] (re sign); a negative value SHALL map to 1.
REQ-020 Packing: subcarrier k of a 4-group SHALL occupy byte bits [2k+1:2k], so the first sample lands in the LSBs; 224 samples SHALL give 56 bytes.
REQ-021 A completed byte SHALL be pushed to the FIFO in the cycle after its 4th capture.
REQ-022 m_valid SHALL equal FIFO non-empty; a byte transfers when m_valid and m_ready are both 1; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 Push and pop in the same cycle SHALL leave fifo_count unchanged; a push while full SHALL not occur, per REQ-017.
REQ-024 After the last address is issued, the FSM SHALL enter DRAIN until all captures are done and the FIFO is empty.
REQ-025 DONE SHALL assert tx_done for exactly one cycle, then go to IDLE; IDLE SHALL ignore out_buff_full in the cycle following tx_done.
REQ-026 Latency from out_buff_full rising, with m_ready tied 1, to the first m_valid SHALL be RD_LAT+5 cycles.
REQ-027 out_buff_full falling during READ or DRAIN SHALL be ignored; the burst completes.

Reset
REQ-028 On rst_n=0: state=IDLE, read_ptr=0, tx_done=0, m_data=0, m_valid=0, FIFO empty, all counters 0, asynchronously.
REQ-029 Reset deassertion mid-burst SHALL restart in IDLE; a partial burst SHALL be discarded with no tx_done.

Configuration
REQ-030 Macro DEMAP_DESCRAMBLE_EN defined: each byte SHALL be XORed, before the FIFO push, with 8 successive bits of PRBS x^7+x^4+1, seeded 7'h7F at each IDLE->READ transition.
REQ-031 Macro DEMAP_DESCRAMBLE_EN undefined: bytes SHALL pass unmodified and no PRBS logic is present.

Verification
REQ-032 All 224 samples = 16'h8080, m_ready=1 -> 56 bytes of 8'hFF, then one tx_done pulse.
REQ-033 Samples alternate 16'h7F80 / 16'h807F -> every byte is 8'h99.
REQ-034 m_ready=0 for 50 cycles mid-burst -> m_valid held, m_data stable, read_ptr frozen, no byte lost; 56 bytes total.
REQ-035 rst_n pulsed low at rd_cnt=100 -> all outputs at reset values, no tx_done; the next out_buff_full gives a full 56-byte burst.
REQ-036 DEMAP_DESCRAMBLE_EN defined, all-zero samples (16'h0000) -> output equals the first 448 PRBS bits from seed 7'h7F, packed LSB-first.
